// File: rtl/slurm32_cpu_decode_sb_pkg.sv
// Shared decode definitions: instruction classes, link registers and field extractors.
package slurm32_cpu_decode_sb_pkg;

   localparam int unsigned INS_BITS   = 32;
   localparam int unsigned FIELD_BITS = 4;

   localparam logic [FIELD_BITS-1:0] LINK_REGISTER           = 4'd15;
   localparam logic [FIELD_BITS-1:0] INTERRUPT_LINK_REGISTER = 4'd14;

   // Opcode byte ins[31:24]; '?' bits are don't-care sub-operations
   localparam logic [7:0] CLS_RET        = 8'b0001_0000;
   localparam logic [7:0] CLS_IRET       = 8'b0001_0001;
   localparam logic [7:0] CLS_ALU_SINGLE = 8'b0010_????;
   localparam logic [7:0] CLS_ALU_RR     = 8'b0011_????;
   localparam logic [7:0] CLS_COND_RR    = 8'b0100_????;
   localparam logic [7:0] CLS_ALU_RI     = 8'b0101_????;
   localparam logic [7:0] CLS_BRANCH     = 8'b0110_????;
   localparam logic [7:0] CLS_LOAD       = 8'b0111_????;
   localparam logic [7:0] CLS_STORE      = 8'b1000_????;

   typedef struct packed {
      logic [FIELD_BITS-1:0] rega;
      logic [FIELD_BITS-1:0] regb;
      logic [FIELD_BITS-1:0] regc;
      logic                  wr_en;
      logic [FIELD_BITS-1:0] wr_sel;
   } dec_t;

   function automatic logic [FIELD_BITS-1:0] reg_dst_from_ins(input logic [INS_BITS-1:0] ins);
      return ins[23:20];
   endfunction

   function automatic logic [FIELD_BITS-1:0] reg_src_from_ins(input logic [INS_BITS-1:0] ins);
      return ins[19:16];
   endfunction

   function automatic logic [FIELD_BITS-1:0] reg_src2_from_ins(input logic [INS_BITS-1:0] ins);
      return ins[15:12];
   endfunction

   function automatic logic [FIELD_BITS-1:0] reg_branch_ind_from_ins(input logic [INS_BITS-1:0] ins);
      return ins[11:8];
   endfunction

   function automatic logic is_ret_or_iret(input logic [INS_BITS-1:0] ins);
      return (ins[31:24] == CLS_RET) || (ins[31:24] == CLS_IRET);
   endfunction

   // Register selects for one instruction; a write to r0 is never reported
   function automatic dec_t decode_ins(input logic [INS_BITS-1:0] ins);
      dec_t d;
      logic dst_used;
      d        = '0;
      dst_used = 1'b0;
      if (is_ret_or_iret(ins)) begin
         d.rega = (ins[31:24] == CLS_IRET) ? INTERRUPT_LINK_REGISTER : LINK_REGISTER;
      end else begin
         casez (ins[31:24])
            CLS_ALU_SINGLE: begin
               d.regb   = reg_src2_from_ins(ins);
               dst_used = 1'b1;
            end
            CLS_ALU_RR, CLS_COND_RR: begin
               d.rega   = reg_src_from_ins(ins);
               d.regb   = reg_src2_from_ins(ins);
               dst_used = 1'b1;
            end
            CLS_ALU_RI, CLS_LOAD: begin
               d.rega   = reg_src_from_ins(ins);
               dst_used = 1'b1;
            end
            CLS_BRANCH: d.rega = reg_branch_ind_from_ins(ins);
            CLS_STORE: begin
               d.rega = reg_src_from_ins(ins);
               d.regc = reg_src2_from_ins(ins);
            end
            default: ;
         endcase
      end
      if (dst_used && (reg_dst_from_ins(ins) != '0)) begin
         d.wr_en  = 1'b1;
         d.wr_sel = reg_dst_from_ins(ins);
      end
      return d;
   endfunction

endpackage

// File: rtl/slurm32_cpu_scoreboard.sv
// Per-register in-flight write counters with pending/full status.
// SLURM32_DECODE_SB_BYPASS_EN: a counter at 1 retiring this cycle is not reported pending.
module slurm32_cpu_scoreboard
   import slurm32_cpu_decode_sb_pkg::*;
#(
   parameter int unsigned REGISTER_BITS = 4,
   parameter int unsigned CNT_BITS      = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_inc_en,
   input  logic [REGISTER_BITS-1:0]      i_inc_sel,
   input  logic                          i_dec_en,
   input  logic [REGISTER_BITS-1:0]      i_dec_sel,
   output logic [(2**REGISTER_BITS)-1:0] o_pending_c,
   output logic [(2**REGISTER_BITS)-1:0] o_full_c
);

   localparam int unsigned NREGS = 2**REGISTER_BITS;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   logic [CNT_BITS-1:0] r_cnt [NREGS];
   logic [NREGS-1:0]    w_inc;
   logic [NREGS-1:0]    w_dec;

   always_comb begin
      w_inc       = '0;
      w_dec       = '0;
      o_pending_c = '0;
      o_full_c    = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         w_inc[i]    = i_inc_en && (i_inc_sel == REGISTER_BITS'(i));
         w_dec[i]    = i_dec_en && (i_dec_sel == REGISTER_BITS'(i));
         o_full_c[i] = (r_cnt[i] == CNT_MAX);
`ifdef SLURM32_DECODE_SB_BYPASS_EN
         o_pending_c[i] = (r_cnt[i] != '0) && !(w_dec[i] && (r_cnt[i] == CNT_BITS'(1)));
`else
         o_pending_c[i] = (r_cnt[i] != '0);
`endif
      end
   end

   // Simultaneous issue and writeback to one register cancel out
   always_ff @(posedge i_clk) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (i_rst) begin
            r_cnt[i] <= '0;
         end else if (w_inc[i] && !w_dec[i]) begin
            r_cnt[i] <= r_cnt[i] + CNT_BITS'(1);
         end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
            r_cnt[i] <= r_cnt[i] - CNT_BITS'(1);
         end
      end
   end

   a_wb_to_idle: assert property (@(posedge i_clk) disable iff (i_rst)
      i_dec_en |-> (r_cnt[i_dec_sel] != '0))
      else $error("writeback retired to a register with no write in flight");

endmodule

// File: rtl/slurm32_cpu_decode_sb.sv
// Decode stage: one holding register, register selects and scoreboard hazard stall.
// SLURM32_DECODE_SB_BYPASS_EN lets a source issue in the same cycle as its final writeback.
module slurm32_cpu_decode_sb
   import slurm32_cpu_decode_sb_pkg::*;
#(
   parameter int unsigned BITS          = 32,
   parameter int unsigned REGISTER_BITS = 4,
   parameter int unsigned CNT_BITS      = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BITS-1:0]          instruction,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BITS-1:0]          out_instruction,
   output logic [REGISTER_BITS-1:0] regA_sel,
   output logic [REGISTER_BITS-1:0] regB_sel,
   output logic [REGISTER_BITS-1:0] regC_sel,
   output logic                     wr_en,
   output logic [REGISTER_BITS-1:0] wr_sel,
   input  logic                     wb_valid,
   input  logic [REGISTER_BITS-1:0] wb_sel
);

   localparam int unsigned NREGS = 2**REGISTER_BITS;

   logic                     r_held;
   logic [BITS-1:0]          r_ins;
   logic [REGISTER_BITS-1:0] r_rega;
   logic [REGISTER_BITS-1:0] r_regb;
   logic [REGISTER_BITS-1:0] r_regc;
   logic                     r_wr_en;
   logic [REGISTER_BITS-1:0] r_wr_sel;

   dec_t                     w_dec;
   logic [REGISTER_BITS-1:0] w_wr_sel;
   logic                     w_wr_en;
   logic [NREGS-1:0]         w_pending;
   logic [NREGS-1:0]         w_full;
   logic                     w_hazard;
   logic                     w_issue;
   logic                     w_accept;

   always_comb begin
      w_dec    = decode_ins(INS_BITS'(instruction));
      w_wr_sel = REGISTER_BITS'(w_dec.wr_sel);
      w_wr_en  = w_dec.wr_en && (w_wr_sel != '0);
   end

   // Stall on any in-flight source write, or a destination counter about to overflow
   always_comb begin
      w_hazard = 1'b0;
      if ((r_rega != '0) && w_pending[r_rega]) w_hazard = 1'b1;
      if ((r_regb != '0) && w_pending[r_regb]) w_hazard = 1'b1;
      if ((r_regc != '0) && w_pending[r_regc]) w_hazard = 1'b1;
      if (r_wr_en && w_full[r_wr_sel])          w_hazard = 1'b1;
   end

   assign out_valid = r_held && !w_hazard;
   assign w_issue   = out_valid && out_ready;
   assign in_ready  = !r_held || w_issue;
   assign w_accept  = in_valid && in_ready;

   // Flush wins over a same-cycle accept; issue+accept replaces contents without a bubble
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_held   <= 1'b0;
         r_ins    <= '0;
         r_rega   <= '0;
         r_regb   <= '0;
         r_regc   <= '0;
         r_wr_en  <= 1'b0;
         r_wr_sel <= '0;
      end else if (flush) begin
         r_held <= 1'b0;
      end else if (w_accept) begin
         r_held   <= 1'b1;
         r_ins    <= instruction;
         r_rega   <= REGISTER_BITS'(w_dec.rega);
         r_regb   <= REGISTER_BITS'(w_dec.regb);
         r_regc   <= REGISTER_BITS'(w_dec.regc);
         r_wr_en  <= w_wr_en;
         r_wr_sel <= w_wr_en ? w_wr_sel : '0;
      end else if (w_issue) begin
         r_held <= 1'b0;
      end
   end

   slurm32_cpu_scoreboard #(
      .REGISTER_BITS (REGISTER_BITS),
      .CNT_BITS      (CNT_BITS)
   ) u_sb (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_inc_en    (w_issue && r_wr_en),
      .i_inc_sel   (r_wr_sel),
      .i_dec_en    (wb_valid),
      .i_dec_sel   (wb_sel),
      .o_pending_c (w_pending),
      .o_full_c    (w_full)
   );

   assign out_instruction = r_ins;
   assign regA_sel        = r_rega;
   assign regB_sel        = r_regb;
   assign regC_sel        = r_regc;
   assign wr_en           = r_wr_en;
   assign wr_sel          = r_wr_sel;

endmodule
